// File: rtl/encoder_channel_ctrl.sv
// rtl/encoder_channel_ctrl.sv - encoder/button driven RGB channel value registers
// Optional detent acceleration is built when ENC_ACCEL_EN is defined.
module encoder_channel_ctrl #(
    parameter int WIDTH           = 8,
    parameter int INCREMENT       = 1,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int ACCEL_WINDOW    = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a,
    input  logic             b,
    input  logic             btn,
    output logic [WIDTH-1:0] red,
    output logic [WIDTH-1:0] green,
    output logic [WIDTH-1:0] blue,
    output logic [1:0]       sel,
    output logic             changed
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [WIDTH:0] MAXV     = {1'b0, {WIDTH{1'b1}}};
    localparam logic [WIDTH:0] STEP_1   = (WIDTH+1)'(INCREMENT);

    // Parameter sanity is checked once at elaboration.
    if (DEBOUNCE_CYCLES < 2 || ACCEL_WINDOW < 1) begin : g_param_check
        $error("encoder_channel_ctrl: DEBOUNCE_CYCLES must be >= 2 and ACCEL_WINDOW >= 1");
    end

    typedef enum logic [1:0] {SEL_R = 2'd0, SEL_G = 2'd1, SEL_B = 2'd2} sel_t;

    sel_t           sel_q;
    logic           old_a, old_b;
    logic [3:0]     dec;
    logic           up_step, dn_step;
    logic [WIDTH:0] cur, step_amt, sum, nxt;
    logic [CW-1:0]  cnt;
    logic           level;
    logic           mismatch, flip, press;

    assign sel = sel_q;
    assign dec = {a, old_a, b, old_b};

    assign mismatch = (btn != level);
    assign flip     = mismatch && (cnt == CNT_LAST);
    assign press    = flip && btn;

`ifdef ENC_ACCEL_EN
    localparam int GW = $clog2(ACCEL_WINDOW + 1);
    localparam logic [GW-1:0]  GAP_MAX = GW'(ACCEL_WINDOW);
    localparam logic [WIDTH:0] STEP_4  = (WIDTH+1)'(4 * INCREMENT);

    logic [GW-1:0] gap;
    logic          last_up;

    // Fast repeated turns in one direction take a 4x step.
    assign step_amt = ((gap < GAP_MAX) && (last_up == up_step)) ? STEP_4 : STEP_1;

    // Cycles since the last step and its direction; a new channel starts unaccelerated.
    always_ff @(posedge clk) begin
        if (reset || press) begin
            gap     <= GAP_MAX;
            last_up <= 1'b0;
        end else if (up_step || dn_step) begin
            gap     <= '0;
            last_up <= up_step;
        end else if (gap < GAP_MAX) begin
            gap <= gap + 1'b1;
        end
    end
`else
    assign step_amt = STEP_1;
`endif

    // Quadrature decode and saturating next value of the selected channel.
    always_comb begin
        up_step = (dec == 4'b1000) || (dec == 4'b0111);
        dn_step = (dec == 4'b0010) || (dec == 4'b1101);
        case (sel_q)
            SEL_G:   cur = {1'b0, green};
            SEL_B:   cur = {1'b0, blue};
            default: cur = {1'b0, red};
        endcase
        sum = cur + step_amt;
        nxt = cur;
        if (up_step) begin
            nxt = (sum > MAXV) ? MAXV : sum;
        end else if (dn_step) begin
            nxt = (cur < step_amt) ? '0 : cur - step_amt;
        end
    end

    // Phase history, channel registers and the change strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            old_a   <= 1'b0;
            old_b   <= 1'b0;
            red     <= '0;
            green   <= '0;
            blue    <= '0;
            changed <= 1'b0;
        end else begin
            old_a   <= a;
            old_b   <= b;
            changed <= (nxt != cur);
            if (nxt != cur) begin
                case (sel_q)
                    SEL_G:   green <= nxt[WIDTH-1:0];
                    SEL_B:   blue  <= nxt[WIDTH-1:0];
                    default: red   <= nxt[WIDTH-1:0];
                endcase
            end
        end
    end

    // Button debounce: accept a new level after it has persisted long enough.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (flip) begin
            cnt   <= '0;
            level <= btn;
        end else if (mismatch) begin
            cnt <= cnt + 1'b1;
        end else begin
            cnt <= '0;
        end
    end

    // Channel selection FSM, advanced by debounced presses only.
    always_ff @(posedge clk) begin
        if (reset) begin
            sel_q <= SEL_R;
        end else if (press) begin
            case (sel_q)
                SEL_R:   sel_q <= SEL_G;
                SEL_G:   sel_q <= SEL_B;
                default: sel_q <= SEL_R;
            endcase
        end
    end

endmodule

// File: tb/tb_encoder_channel_ctrl.sv
// tb/tb_encoder_channel_ctrl.sv - self-checking bench for encoder_channel_ctrl
module tb_encoder_channel_ctrl;

    localparam int W   = 8;
    localparam int INC = 1;
    localparam int DEB = 4;
    localparam int AW  = 16;
    localparam int VMAX = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         reset, a, b, btn;
    logic [W-1:0] red, green, blue;
    logic [1:0]   sel;
    logic         changed;

    encoder_channel_ctrl #(
        .WIDTH(W), .INCREMENT(INC), .DEBOUNCE_CYCLES(DEB), .ACCEL_WINDOW(AW)
    ) dut (
        .clk(clk), .reset(reset), .a(a), .b(b), .btn(btn),
        .red(red), .green(green), .blue(blue), .sel(sel), .changed(changed)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int m_val[3];
    int m_sel, m_run, cyc, last_cyc, last_dir;
    bit m_pa, m_pb, m_level, m_changed, acc_ok;
    bit cur_a, cur_b, cur_btn;

    function automatic int gpos(bit x, bit y);
        case ({x, y})
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit r, input bit ia, input bit ib, input bit ibt);
        int d, dir, stepv, old, nv;
        bit press;
        if (r) begin
            m_val = '{0, 0, 0};
            m_sel = 0; m_run = 0; m_level = 0; m_changed = 0;
            m_pa = 0; m_pb = 0; acc_ok = 0;
        end else begin
            // gray-code walk: a move forward from an even position is an up step
            d = (gpos(ia, ib) - gpos(m_pa, m_pb) + 4) % 4;
            dir = 0;
            if (gpos(m_pa, m_pb) % 2 == 0) begin
                if (d == 1) dir = 1;
                else if (d == 3) dir = -1;
            end
            stepv = INC;
`ifdef ENC_ACCEL_EN
            if (dir != 0 && acc_ok && dir == last_dir && (cyc - last_cyc - 1) < AW)
                stepv = 4 * INC;
`endif
            press = 0;
            if (ibt != m_level) begin
                m_run++;
                if (m_run == DEB) begin
                    m_level = ibt;
                    m_run = 0;
                    press = m_level;
                end
            end else begin
                m_run = 0;
            end
            old = m_val[m_sel];
            nv = old + dir * stepv;
            if (nv > VMAX) nv = VMAX;
            if (nv < 0) nv = 0;
            m_val[m_sel] = nv;
            m_changed = (nv != old);
            if (dir != 0) begin
                last_cyc = cyc; last_dir = dir; acc_ok = 1;
            end
            if (press) begin
                m_sel = (m_sel + 1) % 3;
                acc_ok = 0;
            end
            m_pa = ia; m_pb = ib;
        end
        cyc++;
    endtask

    task automatic tick(input bit r);
        reset = r; a = cur_a; b = cur_b; btn = cur_btn;
        @(posedge clk);
        model_edge(r, cur_a, cur_b, cur_btn);
        #1;
        chk("red", red, m_val[0]);
        chk("green", green, m_val[1]);
        chk("blue", blue, m_val[2]);
        chk("sel", sel, m_sel);
        chk("changed", changed, m_changed);
    endtask

    task automatic idle(input int n);
        repeat (n) tick(0);
    endtask

    task automatic detent(input bit up, input int gap);
        if (up) begin
            cur_a = 1; tick(0); cur_b = 1; tick(0); cur_a = 0; tick(0); cur_b = 0; tick(0);
        end else begin
            cur_b = 1; tick(0); cur_a = 1; tick(0); cur_b = 0; tick(0); cur_a = 0; tick(0);
        end
        idle(gap);
    endtask

    task automatic press_btn(input int hold);
        cur_btn = 1; idle(hold);
        cur_btn = 0; idle(DEB + 2);
    endtask

    initial begin
        int pos, rb, gb;
        cyc = 0; last_cyc = 0; last_dir = 0;
        cur_a = 0; cur_b = 0; cur_btn = 0;
        reset = 1; a = 0; b = 0; btn = 0;

        // reset state
        tick(1); tick(1); tick(1);
        chk("rst_red", red, 0);
        chk("rst_green", green, 0);
        chk("rst_blue", blue, 0);
        chk("rst_sel", sel, 0);
        chk("rst_changed", changed, 0);

        // up then down on red
        repeat (5) detent(1, 32);
`ifndef ENC_ACCEL_EN
        chk("red_up5", red, 10);
`endif
        repeat (2) detent(0, 32);
`ifndef ENC_ACCEL_EN
        chk("red_dn2", red, 6);
`endif
        chk("green_idle", green, 0);

        // debounce
        press_btn(3);
        chk("glitch_sel", sel, 0);
        press_btn(4);
        chk("press_sel", sel, 1);

        // green saturation at the top
        repeat (127) detent(1, 0);
`ifndef ENC_ACCEL_EN
        chk("green_254", green, 254);
`endif
        detent(1, 2);
        chk("green_255", green, 255);

        // blue saturation at the bottom
        press_btn(4);
        chk("sel_b", sel, 2);
        repeat (2) detent(0, 2);
        chk("blue_0", blue, 0);
        press_btn(4);
        chk("sel_wrap", sel, 0);

        // step and press land on the same edge
        rb = red; gb = green;
        cur_btn = 1; idle(DEB - 1);
        cur_a = 1; tick(0);
        chk("sim_red", red, rb + 1);
        chk("sim_sel", sel, 1);
        chk("sim_green", green, gb);
        cur_btn = 0;
        cur_b = 1; tick(0); cur_a = 0; tick(0); cur_b = 0; tick(0);
        idle(DEB + 2);

        // reset mid-operation, first cycle decodes against cleared history
        cur_btn = 1; idle(2);
        cur_a = 1; cur_b = 0;
        tick(1); tick(1);
        cur_btn = 0;
        tick(0);
        chk("post_rst_red", red, 1);
        chk("post_rst_sel", sel, 0);
        cur_a = 0; idle(4);

        // randomized walk with bouncing button and rare resets
        pos = gpos(cur_a, cur_b);
        repeat (3000) begin
            case ($urandom_range(0, 3))
                0: pos = (pos + 1) % 4;
                1: pos = (pos + 3) % 4;
                default: ;
            endcase
            cur_a = (pos == 1 || pos == 2);
            cur_b = (pos == 2 || pos == 3);
            if ($urandom_range(0, 5) == 0) cur_btn = ~cur_btn;
            tick($urandom_range(0, 499) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
